// File: rtl/qspi_psram_responder.sv
// QSPI/QPI PSRAM responder: oversampled quad command/address/data backed by an internal byte array.
// Optional QSPI_RESP_PAGE_WRAP_EN: burst address increments wrap inside a 1024-byte page.
module qspi_psram_responder #(
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned ADR_W    = 12,
  parameter int unsigned WAIT_CYC = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] sio_in,
  output logic [3:0] sio_out,
  output logic       sio_oe,
  output logic       cmd_err,
  output logic       busy
);
  localparam int unsigned A_W    = 24;
  localparam int unsigned CNT_W  = 8;
  localparam logic [7:0]  CMD_RD = 8'hEB;
  localparam logic [7:0]  CMD_WR = 8'h38;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADR, ST_WAIT, ST_RDATA, ST_WDATA, ST_IGNORE
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         sck_q;
  logic [1:0]         ce_q;
  logic [3:0]         sio_q1, sio_q2;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         sh_q, sh_d;
  logic [A_W-1:0]     adr_q, adr_d;
  logic               rd_q, rd_d;
  logic               nib_q, nib_d;
  logic [3:0]         wbuf_q, wbuf_d;
  logic [3:0]         sio_out_q, sio_out_d;
  logic               sio_oe_q, sio_oe_d;
  logic               cmd_err_q, cmd_err_d;
  logic               busy_q, busy_d;
  logic               mem_we_c;
  logic [7:0]         mem_wdata_c;
  logic [7:0]         mem_q [DEPTH];

  logic               sck_rise_c, sck_fall_c, ce_s_c;
  logic [3:0]         sio_s_c;
  logic [ADR_W-1:0]   idx_c;
  logic [7:0]         rd_byte_c;
  logic [7:0]         cmd_c;

  assign sck_rise_c = sck_q[1] & ~sck_q[2];
  assign sck_fall_c = ~sck_q[1] & sck_q[2];
  assign ce_s_c     = ce_q[1];
  assign sio_s_c    = sio_q2;
  assign idx_c      = adr_q[ADR_W-1:0];
  assign rd_byte_c  = mem_q[idx_c];
  assign cmd_c      = {sh_q, sio_s_c};

  function automatic logic [A_W-1:0] adr_inc(input logic [A_W-1:0] a);
`ifdef QSPI_RESP_PAGE_WRAP_EN
    adr_inc = {a[A_W-1:10], a[9:0] + 10'd1};
`else
    adr_inc = a + A_W'(1);
`endif
  endfunction

  // Two-flop synchronisers; the third sck flop provides the edge reference.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= '0;
      ce_q   <= '1;
      sio_q1 <= '0;
      sio_q2 <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      ce_q   <= {ce_q[0], ce_n};
      sio_q1 <= sio_in;
      sio_q2 <= sio_q1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      adr_q     <= '0;
      rd_q      <= 1'b0;
      nib_q     <= 1'b0;
      wbuf_q    <= '0;
      sio_out_q <= '0;
      sio_oe_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      adr_q     <= adr_d;
      rd_q      <= rd_d;
      nib_q     <= nib_d;
      wbuf_q    <= wbuf_d;
      sio_out_q <= sio_out_d;
      sio_oe_q  <= sio_oe_d;
      cmd_err_q <= cmd_err_d;
      busy_q    <= busy_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) mem_q[idx_c] <= mem_wdata_c;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    adr_d       = adr_q;
    rd_d        = rd_q;
    nib_d       = nib_q;
    wbuf_d      = wbuf_q;
    sio_out_d   = sio_out_q;
    cmd_err_d   = cmd_err_q;
    mem_we_c    = 1'b0;
    mem_wdata_c = {wbuf_q, sio_s_c};

    // Deasserted chip enable overrides any coincident sck edge.
    if (state_q != ST_IDLE && ce_s_c) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!ce_s_c) begin
            state_d = ST_CMD;
            cnt_d   = '0;
            nib_d   = 1'b0;
          end
        end
        ST_CMD: begin
          if (sck_rise_c) begin
            sh_d  = sio_s_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              cnt_d = '0;
              if (cmd_c == CMD_RD) begin
                state_d = ST_ADR;
                rd_d    = 1'b1;
              end else if (cmd_c == CMD_WR) begin
                state_d = ST_ADR;
                rd_d    = 1'b0;
              end else begin
                state_d   = ST_IGNORE;
                cmd_err_d = 1'b1;
              end
            end
          end
        end
        ST_ADR: begin
          if (sck_rise_c) begin
            adr_d = {adr_q[A_W-5:0], sio_s_c};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(5)) begin
              cnt_d   = '0;
              nib_d   = 1'b0;
              state_d = rd_q ? ST_WAIT : ST_WDATA;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_W'(WAIT_CYC)) begin
            if (sck_fall_c) begin
              sio_out_d = rd_byte_c[7:4];
              nib_d     = 1'b1;
              state_d   = ST_RDATA;
            end
          end else if (sck_rise_c) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RDATA: begin
          if (sck_fall_c) begin
            if (nib_q) begin
              sio_out_d = rd_byte_c[3:0];
              adr_d     = adr_inc(adr_q);
              nib_d     = 1'b0;
            end else begin
              sio_out_d = rd_byte_c[7:4];
              nib_d     = 1'b1;
            end
          end
        end
        ST_WDATA: begin
          if (sck_rise_c) begin
            if (!nib_q) begin
              wbuf_d = sio_s_c;
              nib_d  = 1'b1;
            end else begin
              mem_we_c = 1'b1;
              adr_d    = adr_inc(adr_q);
              nib_d    = 1'b0;
            end
          end
        end
        ST_IGNORE: begin
          state_d = ST_IGNORE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    sio_oe_d = (state_d == ST_RDATA);
    busy_d   = (state_d != ST_IDLE);
  end

  assign sio_out = sio_out_q;
  assign sio_oe  = sio_oe_q;
  assign cmd_err = cmd_err_q;
  assign busy    = busy_q;

endmodule
